// File: rtl/rename_reg_file_pkg.sv
// Shared widths and rename-state types for the architectural register file
// and its per-source lookup logic.
package rename_reg_file_pkg;

    localparam int REG_NUM_BIT   = 5;
    localparam int ROB_WIDTH_BIT = 5;
    localparam int NUM_REGS      = 1 << REG_NUM_BIT;

    typedef logic [REG_NUM_BIT-1:0]   reg_id_t;
    typedef logic [ROB_WIDTH_BIT-1:0] rob_id_t;

    // Rename state of one architectural register.
    typedef struct packed {
        logic    busy;
        rob_id_t tag;
    } rename_t;

endpackage

// File: rtl/reg_src_lookup.sv
// Priority lookup for one decoder source: x0, then commit bypass,
// then the in-flight ROB entry, then the committed register value.
module reg_src_lookup
    import rename_reg_file_pkg::*;
(
    input  logic [REG_NUM_BIT-1:0]   rs_id,
    input  logic                     busy,
    input  logic [ROB_WIDTH_BIT-1:0] tag,
    input  logic [31:0]              value,
    input  logic [REG_NUM_BIT-1:0]   commit_reg_id,
    input  logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
    input  logic [31:0]              commit_val,
    input  logic                     rob_ready,
    input  logic [31:0]              rob_val,
    output logic                     ready,
    output logic [31:0]              val,
    output logic [ROB_WIDTH_BIT-1:0] dep,
    output logic [ROB_WIDTH_BIT-1:0] rob_id
);

    always_comb begin
        // NOTE: every output gets a default before any branch so no path
        // leaves a variable unassigned and infers a latch.
        ready  = 1'b1;
        val    = value;
        dep    = '0;
        rob_id = '0;
        if (rs_id == '0) begin
            val = '0;
        end else if (busy) begin
            dep    = tag;
            rob_id = tag;
            if (commit_reg_id == rs_id && commit_rob_id == tag) begin
                val = commit_val;
            end else begin
                ready = rob_ready;
                val   = rob_val;
            end
        end
    end

endmodule

// File: rtl/rename_reg_file.sv
// Architectural register file with rename tags: commits from the ROB head,
// renames from the ROB tail, flush on mispredict, two combinational lookups.
module rename_reg_file
    import rename_reg_file_pkg::*;
(
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     rdy_in,
    input  logic                     clear_in,
    input  logic [REG_NUM_BIT-1:0]   commit_reg_id,
    input  logic [31:0]              commit_val,
    input  logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
    input  logic [REG_NUM_BIT-1:0]   new_reg_id,
    input  logic [ROB_WIDTH_BIT-1:0] new_rob_id,
    input  logic [REG_NUM_BIT-1:0]   rs1_id,
    input  logic [REG_NUM_BIT-1:0]   rs2_id,
    output logic                     rs1_ready,
    output logic                     rs2_ready,
    output logic [31:0]              rs1_val,
    output logic [31:0]              rs2_val,
    output logic [ROB_WIDTH_BIT-1:0] rs1_dep,
    output logic [ROB_WIDTH_BIT-1:0] rs2_dep,
    output logic [ROB_WIDTH_BIT-1:0] rob_rs1_id,
    output logic [ROB_WIDTH_BIT-1:0] rob_rs2_id,
    input  logic                     rob_rs1_ready,
    input  logic                     rob_rs2_ready,
    input  logic [31:0]              rob_rs1_val,
    input  logic [31:0]              rob_rs2_val
);

    // Entry 0 is reset to zero and never loaded, so x0 reads as a constant.
    logic [31:0] value_q  [NUM_REGS];
    rename_t     rename_q [NUM_REGS];

    logic commit_en;
    logic rename_en;
    logic commit_retires;

    assign commit_en      = (commit_reg_id != '0);
    assign rename_en      = (new_reg_id != '0);
    assign commit_retires = commit_en && rename_q[commit_reg_id].busy
                            && (rename_q[commit_reg_id].tag == commit_rob_id);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            // NOTE: this array is architectural state that must read as zero
            // after reset, so unlike a plain RAM every entry is reset here.
            for (int r = 0; r < NUM_REGS; r++) begin
                value_q[r]  <= '0;
                rename_q[r] <= '0;
            end
        end else if (rdy_in) begin
            if (commit_en) begin
                value_q[commit_reg_id] <= commit_val;
            end
            if (clear_in) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    rename_q[r] <= '0;
                end
            end else begin
                if (commit_retires) begin
                    rename_q[commit_reg_id].busy <= 1'b0;
                end
                // NOTE: non-blocking updates to the same element resolve to the
                // last one written, so a same-register rename beats the retire.
                if (rename_en) begin
                    rename_q[new_reg_id].busy <= 1'b1;
                    rename_q[new_reg_id].tag  <= new_rob_id;
                end
            end
        end
    end

    reg_src_lookup u_rs1 (
        .rs_id         (rs1_id),
        .busy          (rename_q[rs1_id].busy),
        .tag           (rename_q[rs1_id].tag),
        .value         (value_q[rs1_id]),
        .commit_reg_id (commit_reg_id),
        .commit_rob_id (commit_rob_id),
        .commit_val    (commit_val),
        .rob_ready     (rob_rs1_ready),
        .rob_val       (rob_rs1_val),
        .ready         (rs1_ready),
        .val           (rs1_val),
        .dep           (rs1_dep),
        .rob_id        (rob_rs1_id)
    );

    reg_src_lookup u_rs2 (
        .rs_id         (rs2_id),
        .busy          (rename_q[rs2_id].busy),
        .tag           (rename_q[rs2_id].tag),
        .value         (value_q[rs2_id]),
        .commit_reg_id (commit_reg_id),
        .commit_rob_id (commit_rob_id),
        .commit_val    (commit_val),
        .rob_ready     (rob_rs2_ready),
        .rob_val       (rob_rs2_val),
        .ready         (rs2_ready),
        .val           (rs2_val),
        .dep           (rs2_dep),
        .rob_id        (rob_rs2_id)
    );

endmodule

// File: tb/tb_rename_reg_file.sv
// Directed scenarios followed by randomized traffic, compared against an
// array-based model of committed values and outstanding producers.
module tb_rename_reg_file;
    import rename_reg_file_pkg::*;

    logic                     clk_in = 1'b0;
    logic                     rst_n_in;
    logic                     rdy_in;
    logic                     clear_in;
    logic [REG_NUM_BIT-1:0]   commit_reg_id;
    logic [31:0]              commit_val;
    logic [ROB_WIDTH_BIT-1:0] commit_rob_id;
    logic [REG_NUM_BIT-1:0]   new_reg_id;
    logic [ROB_WIDTH_BIT-1:0] new_rob_id;
    logic [REG_NUM_BIT-1:0]   rs1_id, rs2_id;
    logic                     rs1_ready, rs2_ready;
    logic [31:0]              rs1_val, rs2_val;
    logic [ROB_WIDTH_BIT-1:0] rs1_dep, rs2_dep;
    logic [ROB_WIDTH_BIT-1:0] rob_rs1_id, rob_rs2_id;
    logic                     rob_rs1_ready, rob_rs2_ready;
    logic [31:0]              rob_rs1_val, rob_rs2_val;

    int vectors    = 0;
    int miscompares = 0;

    // Reference: committed value per register, and the ROB tag still owed (if any).
    logic [31:0]              m_val     [NUM_REGS];
    bit                       m_pending [NUM_REGS];
    logic [ROB_WIDTH_BIT-1:0] m_owner   [NUM_REGS];

    always #5 clk_in = ~clk_in;

    rename_reg_file dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .commit_reg_id(commit_reg_id), .commit_val(commit_val), .commit_rob_id(commit_rob_id),
        .new_reg_id(new_reg_id), .new_rob_id(new_rob_id),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
        .rs1_val(rs1_val), .rs2_val(rs2_val),
        .rs1_dep(rs1_dep), .rs2_dep(rs2_dep),
        .rob_rs1_id(rob_rs1_id), .rob_rs2_id(rob_rs2_id),
        .rob_rs1_ready(rob_rs1_ready), .rob_rs2_ready(rob_rs2_ready),
        .rob_rs1_val(rob_rs1_val), .rob_rs2_val(rob_rs2_val)
    );

    task automatic model_reset();
        for (int r = 0; r < NUM_REGS; r++) begin
            m_val[r] = '0; m_pending[r] = 0; m_owner[r] = '0;
        end
    endtask

    task automatic idle_inputs();
        rdy_in = 1'b1; clear_in = 1'b0;
        commit_reg_id = '0; commit_val = '0; commit_rob_id = '0;
        new_reg_id = '0; new_rob_id = '0;
        rob_rs1_ready = 1'b0; rob_rs2_ready = 1'b0; rob_rs1_val = '0; rob_rs2_val = '0;
    endtask

    // Apply this cycle's commit/rename/flush to the model, then clock the DUT.
    task automatic tick();
        if (rdy_in) begin
            if (commit_reg_id != 0) begin
                m_val[commit_reg_id] = commit_val;
                if (m_pending[commit_reg_id] && m_owner[commit_reg_id] == commit_rob_id)
                    m_pending[commit_reg_id] = 0;
            end
            if (new_reg_id != 0) begin
                m_pending[new_reg_id] = 1; m_owner[new_reg_id] = new_rob_id;
            end
            if (clear_in) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    m_pending[r] = 0; m_owner[r] = '0;
                end
            end
        end
        @(posedge clk_in); #1;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0; idle_inputs(); rs1_id = 5'd5; rs2_id = 5'd0;
        model_reset();
        repeat (2) @(posedge clk_in);
        #1 rst_n_in = 1'b1; #1;
        vectors++; if (rs1_ready !== 1'b1) begin miscompares++; $display("FAIL reset_rs1_ready got %0h want 1", rs1_ready); end
        vectors++; if (rs2_ready !== 1'b1) begin miscompares++; $display("FAIL reset_rs2_ready got %0h want 1", rs2_ready); end
        vectors++; if (rs1_val !== 32'h0) begin miscompares++; $display("FAIL reset_rs1_val got %0h want 0", rs1_val); end
        vectors++; if (rs2_val !== 32'h0) begin miscompares++; $display("FAIL reset_rs2_val got %0h want 0", rs2_val); end
        vectors++; if (rob_rs1_id !== 5'd0) begin miscompares++; $display("FAIL reset_rob_rs1_id got %0h want 0", rob_rs1_id); end
        vectors++; if (rs1_dep !== 5'd0) begin miscompares++; $display("FAIL reset_rs1_dep got %0h want 0", rs1_dep); end
    endtask

    task automatic test_rename_query();
        new_reg_id = 5'd3; new_rob_id = 5'd7; tick(); idle_inputs();
        rs1_id = 5'd3; rob_rs1_ready = 1'b0; #1;
        vectors++; if (rs1_ready !== 1'b0) begin miscompares++; $display("FAIL rename_ready got %0h want 0", rs1_ready); end
        vectors++; if (rs1_dep !== 5'd7) begin miscompares++; $display("FAIL rename_dep got %0h want 7", rs1_dep); end
        vectors++; if (rob_rs1_id !== 5'd7) begin miscompares++; $display("FAIL rename_rob_id got %0h want 7", rob_rs1_id); end
        rob_rs1_ready = 1'b1; rob_rs1_val = 32'h55; #1;
        vectors++; if (rs1_ready !== 1'b1) begin miscompares++; $display("FAIL rob_fwd_ready got %0h want 1", rs1_ready); end
        vectors++; if (rs1_val !== 32'h55) begin miscompares++; $display("FAIL rob_fwd_val got %0h want 55", rs1_val); end
    endtask

    task automatic test_commit_bypass();
        idle_inputs(); rs1_id = 5'd3;
        commit_reg_id = 5'd3; commit_val = 32'hAB; commit_rob_id = 5'd7; #1;
        vectors++; if (rs1_ready !== 1'b1) begin miscompares++; $display("FAIL bypass_ready got %0h want 1", rs1_ready); end
        vectors++; if (rs1_val !== 32'hAB) begin miscompares++; $display("FAIL bypass_val got %0h want ab", rs1_val); end
        tick(); idle_inputs(); #1;
        vectors++; if (rs1_ready !== 1'b1) begin miscompares++; $display("FAIL retired_ready got %0h want 1", rs1_ready); end
        vectors++; if (rs1_val !== 32'hAB) begin miscompares++; $display("FAIL retired_val got %0h want ab", rs1_val); end
        vectors++; if (rob_rs1_id !== 5'd0) begin miscompares++; $display("FAIL retired_rob_id got %0h want 0", rob_rs1_id); end
    endtask

    task automatic test_younger_rename();
        new_reg_id = 5'd4; new_rob_id = 5'd2; tick();
        new_rob_id = 5'd9; tick(); idle_inputs();
        rs1_id = 5'd4; commit_reg_id = 5'd4; commit_rob_id = 5'd2; commit_val = 32'h11; #1;
        vectors++; if (rs1_ready !== 1'b0) begin miscompares++; $display("FAIL stale_commit_no_bypass got %0h want 0", rs1_ready); end
        tick(); idle_inputs(); #1;
        vectors++; if (rs1_ready !== 1'b0) begin miscompares++; $display("FAIL younger_busy got %0h want 0", rs1_ready); end
        vectors++; if (rs1_dep !== 5'd9) begin miscompares++; $display("FAIL younger_dep got %0h want 9", rs1_dep); end
        commit_reg_id = 5'd4; commit_rob_id = 5'd9; commit_val = 32'h22; tick(); idle_inputs(); #1;
        vectors++; if (rs1_ready !== 1'b1) begin miscompares++; $display("FAIL younger_done_ready got %0h want 1", rs1_ready); end
        vectors++; if (rs1_val !== 32'h22) begin miscompares++; $display("FAIL younger_done_val got %0h want 22", rs1_val); end
    endtask

    task automatic test_same_cycle_commit_rename();
        commit_reg_id = 5'd6; commit_rob_id = 5'd1; commit_val = 32'h33;
        new_reg_id = 5'd6; new_rob_id = 5'd4; tick(); idle_inputs();
        rs2_id = 5'd6; #1;
        vectors++; if (rs2_ready !== 1'b0) begin miscompares++; $display("FAIL same_cycle_busy got %0h want 0", rs2_ready); end
        vectors++; if (rs2_dep !== 5'd4) begin miscompares++; $display("FAIL same_cycle_dep got %0h want 4", rs2_dep); end
        vectors++; if (rob_rs2_id !== 5'd4) begin miscompares++; $display("FAIL same_cycle_rob_id got %0h want 4", rob_rs2_id); end
    endtask

    task automatic test_clear();
        commit_reg_id = 5'd1; commit_val = 32'h101; tick();
        commit_reg_id = 5'd2; commit_val = 32'h202; tick(); idle_inputs();
        new_reg_id = 5'd1; new_rob_id = 5'd3; tick();
        new_reg_id = 5'd2; new_rob_id = 5'd8; tick(); idle_inputs();
        clear_in = 1'b1; commit_reg_id = 5'd8; commit_val = 32'h7; commit_rob_id = 5'd5;
        new_reg_id = 5'd10; new_rob_id = 5'd12; tick(); idle_inputs();
        rs1_id = 5'd1; rs2_id = 5'd2; #1;
        vectors++; if (rs1_ready !== 1'b1 || rs1_val !== 32'h101) begin miscompares++; $display("FAIL clear_x1 got %0h/%0h want 1/101", rs1_ready, rs1_val); end
        vectors++; if (rs2_ready !== 1'b1 || rs2_val !== 32'h202) begin miscompares++; $display("FAIL clear_x2 got %0h/%0h want 1/202", rs2_ready, rs2_val); end
        rs1_id = 5'd8; rs2_id = 5'd6; #1;
        vectors++; if (rs1_ready !== 1'b1 || rs1_val !== 32'h7) begin miscompares++; $display("FAIL clear_commit_x8 got %0h/%0h want 1/7", rs1_ready, rs1_val); end
        vectors++; if (rs2_ready !== 1'b1 || rs2_val !== 32'h33) begin miscompares++; $display("FAIL clear_x6 got %0h/%0h want 1/33", rs2_ready, rs2_val); end
        rs1_id = 5'd10; #1;
        vectors++; if (rs1_ready !== 1'b1 || rob_rs1_id !== 5'd0) begin miscompares++; $display("FAIL clear_drops_rename got %0h/%0h want 1/0", rs1_ready, rob_rs1_id); end
    endtask

    task automatic test_x0();
        commit_reg_id = 5'd0; commit_val = 32'hDEAD; new_reg_id = 5'd0; new_rob_id = 5'd3;
        tick(); idle_inputs(); rs1_id = 5'd0; rs2_id = 5'd0; #1;
        vectors++; if (rs1_ready !== 1'b1 || rs1_val !== 32'h0) begin miscompares++; $display("FAIL x0_rs1 got %0h/%0h want 1/0", rs1_ready, rs1_val); end
        vectors++; if (rob_rs2_id !== 5'd0 || rs2_val !== 32'h0) begin miscompares++; $display("FAIL x0_rs2 got %0h/%0h want 0/0", rob_rs2_id, rs2_val); end
    endtask

    task automatic test_rdy_low();
        rdy_in = 1'b0; clear_in = 1'b0; new_reg_id = 5'd12; new_rob_id = 5'd5;
        commit_reg_id = 5'd1; commit_val = 32'hFFFF; tick(); idle_inputs();
        rs1_id = 5'd12; rs2_id = 5'd1; #1;
        vectors++; if (rs1_ready !== 1'b1 || rob_rs1_id !== 5'd0) begin miscompares++; $display("FAIL stall_rename got %0h/%0h want 1/0", rs1_ready, rob_rs1_id); end
        vectors++; if (rs2_val !== 32'h101) begin miscompares++; $display("FAIL stall_commit got %0h want 101", rs2_val); end
    endtask

    task automatic test_reset_mid();
        new_reg_id = 5'd13; new_rob_id = 5'd6; tick(); idle_inputs();
        rs1_id = 5'd13; rs2_id = 5'd1; #1;
        vectors++; if (rs1_ready !== 1'b0) begin miscompares++; $display("FAIL pre_reset_busy got %0h want 0", rs1_ready); end
        rst_n_in = 1'b0; model_reset(); #1;
        vectors++; if (rs1_ready !== 1'b1 || rob_rs1_id !== 5'd0) begin miscompares++; $display("FAIL async_reset_rename got %0h/%0h want 1/0", rs1_ready, rob_rs1_id); end
        vectors++; if (rs2_val !== 32'h0) begin miscompares++; $display("FAIL async_reset_value got %0h want 0", rs2_val); end
        #1 rst_n_in = 1'b1; @(posedge clk_in); #1;
    endtask

    task automatic test_random();
        logic [REG_NUM_BIT-1:0] ids [2];
        logic rr [2]; logic [31:0] rv [2];
        logic e_ready; logic [31:0] e_val; logic [ROB_WIDTH_BIT-1:0] e_rid; bit bypass;
        for (int n = 0; n < 400; n++) begin
            rdy_in = ($urandom_range(0, 9) != 0);
            clear_in = ($urandom_range(0, 19) == 0);
            commit_reg_id = REG_NUM_BIT'($urandom_range(0, 31));
            commit_val = $urandom();
            commit_rob_id = ($urandom_range(0, 1) == 1) ? m_owner[commit_reg_id] : ROB_WIDTH_BIT'($urandom_range(0, 31));
            new_reg_id = ($urandom_range(0, 2) == 0) ? '0 : REG_NUM_BIT'($urandom_range(0, 31));
            new_rob_id = ROB_WIDTH_BIT'($urandom_range(0, 31));
            rs1_id = ($urandom_range(0, 2) == 0) ? commit_reg_id : REG_NUM_BIT'($urandom_range(0, 31));
            rs2_id = REG_NUM_BIT'($urandom_range(0, 31));
            rob_rs1_ready = 1'($urandom_range(0, 1)); rob_rs2_ready = 1'($urandom_range(0, 1));
            rob_rs1_val = $urandom(); rob_rs2_val = $urandom();
            #1;
            ids[0] = rs1_id; ids[1] = rs2_id;
            rr[0] = rob_rs1_ready; rr[1] = rob_rs2_ready; rv[0] = rob_rs1_val; rv[1] = rob_rs2_val;
            for (int s = 0; s < 2; s++) begin
                bypass = 0; e_rid = '0;
                if (ids[s] == 0) begin
                    e_ready = 1'b1; e_val = '0;
                end else if (m_pending[ids[s]]) begin
                    e_rid = m_owner[ids[s]];
                    bypass = (commit_reg_id == ids[s] && commit_rob_id == m_owner[ids[s]]);
                    e_ready = bypass ? 1'b1 : rr[s];
                    e_val = bypass ? commit_val : rv[s];
                end else begin
                    e_ready = 1'b1; e_val = m_val[ids[s]];
                end
                vectors++;
                if ((s == 0 ? rs1_ready : rs2_ready) !== e_ready ||
                    (e_ready && (s == 0 ? rs1_val : rs2_val) !== e_val) ||
                    (s == 0 ? rob_rs1_id : rob_rs2_id) !== e_rid ||
                    (!bypass && (s == 0 ? rs1_dep : rs2_dep) !== e_rid)) begin
                    miscompares++;
                    $display("FAIL random_rs%0d n=%0d id=%0d got rdy=%0h val=%0h rid=%0h dep=%0h want rdy=%0h val=%0h rid=%0h",
                             s + 1, n, ids[s], (s == 0 ? rs1_ready : rs2_ready), (s == 0 ? rs1_val : rs2_val),
                             (s == 0 ? rob_rs1_id : rob_rs2_id), (s == 0 ? rs1_dep : rs2_dep), e_ready, e_val, e_rid);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_rename_query();
        test_commit_bypass();
        test_younger_rename();
        test_same_cycle_commit_rename();
        test_clear();
        test_x0();
        test_rdy_low();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
